// File: rtl/memctrl_pkg.sv
// Shared encodings for the memory access controller: access sizes, FSM states
// and the latched request record.
package memctrl_pkg;
   localparam int WORD_BYTES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RMW_WRITE = 2'd1,
      RESP      = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0]  size;
      logic [31:0] adr;
      logic [31:0] wdata;
   } lat_t;
endpackage

// File: rtl/memctrl_lanealign.sv
// Big-endian lane steering: sub-word load extraction/extension and
// sub-word store merge into an existing memory word.
module lanealign
   import memctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] ld_word,
   input  logic [1:0]       ld_off,
   input  logic [1:0]       ld_size,
   input  logic             ld_sext,
   output logic [WIDTH-1:0] ld_result,
   input  logic [WIDTH-1:0] st_word,
   input  logic [1:0]       st_off,
   input  logic [1:0]       st_size,
   input  logic [WIDTH-1:0] st_data,
   output logic [WIDTH-1:0] st_merged
);
   // Lane 3 holds bits [31:24], so byte offset N lives in lane ~N.
   logic [WORD_BYTES-1:0][7:0] ld_lanes, st_lanes;
   logic [1:0][15:0]           ld_halves, st_halves;
   logic [7:0]                 ld_byte;
   logic [15:0]                ld_half;

   always_comb begin
      ld_lanes  = ld_word;
      ld_halves = ld_word;
      ld_byte   = ld_lanes[~ld_off];
      ld_half   = ld_halves[~ld_off[1]];
      case (ld_size)
         SZ_BYTE: ld_result = {{(WIDTH-8){ld_sext & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_result = {{(WIDTH-16){ld_sext & ld_half[15]}}, ld_half};
         default: ld_result = ld_word;
      endcase
   end

   always_comb begin
      st_lanes  = st_word;
      st_halves = st_word;
      st_lanes[~st_off]      = st_data[7:0];
      st_halves[~st_off[1]]  = st_data[15:0];
      case (st_size)
         SZ_BYTE: st_merged = st_lanes;
         SZ_HALF: st_merged = st_halves;
         default: st_merged = st_data;
      endcase
   end
endmodule

// File: rtl/memctrl.sv
// One-at-a-time load/store controller; sub-word stores are done as
// read-modify-write on the 32-bit memory word.
module memctrl
   import memctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             we,
   input  logic [1:0]       size,
   input  logic             sext,
   input  logic [WIDTH-1:0] adr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             ready,
   output logic             err,
   output logic             memwrite,
   output logic [WIDTH-1:0] madr,
   output logic [WIDTH-1:0] mwritedata,
   input  logic [WIDTH-1:0] memdata
);
   state_t           state, next;
   lat_t             lat;
   logic [WIDTH-1:0] merge_q, rdata_q, ld_result, st_merged;
   logic             err_q, bad, sub_store;

   assign bad = (size == SZ_RSVD) ||
                (size == SZ_HALF && adr[0]) ||
                (size == SZ_WORD && adr[1:0] != 2'b00);
   assign sub_store = we && (size == SZ_BYTE || size == SZ_HALF);

   lanealign #(.WIDTH(WIDTH)) u_lane (
      .ld_word   (memdata),
      .ld_off    (adr[1:0]),
      .ld_size   (size),
      .ld_sext   (sext),
      .ld_result (ld_result),
      .st_word   (merge_q),
      .st_off    (lat.adr[1:0]),
      .st_size   (lat.size),
      .st_data   (lat.wdata),
      .st_merged (st_merged)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         IDLE: begin
            if (req) next = (!bad && sub_store) ? RMW_WRITE : RESP;
         end
         RMW_WRITE: next = RESP;
         RESP:      next = IDLE;
         default:   next = IDLE;
      endcase
   end

   // Reset suppresses strobes so an interrupted transaction leaves no trace.
   always_comb begin
      ready      = 1'b0;
      memwrite   = 1'b0;
      madr       = {lat.adr[WIDTH-1:2], 2'b00};
      mwritedata = wdata;
      case (state)
         IDLE: begin
            madr     = {adr[WIDTH-1:2], 2'b00};
            memwrite = !reset && req && we && !bad && size == SZ_WORD;
         end
         RMW_WRITE: begin
            memwrite   = !reset;
            mwritedata = st_merged;
         end
         RESP:    ready = !reset;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lat     <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state == IDLE && req) begin
         lat <= '{size: size, adr: adr, wdata: wdata};
         if (bad) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end else begin
            err_q <= 1'b0;
            if (!we)      rdata_q <= ld_result;
            if (sub_store) merge_q <= memdata;
         end
      end
   end

   assign rdata = rdata_q;
   assign err   = err_q;
endmodule

// File: tb/tb_memctrl.sv
// Directed bench for memctrl: expected responses are queued as each request
// is driven and checked when ready arrives, alongside write strobes and memory.
module tb_memctrl;
   import memctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset, req, we, sext, ready, err, memwrite, init_mem;
   logic [1:0]  size;
   logic [31:0] adr, wdata, rdata, madr, mwritedata, memdata;
   logic [31:0] mem [0:255];
   int          cyc = 0;
   int          wr_cnt = 0;
   int          vectors = 0;
   int          miscompares = 0;

   typedef struct {
      logic        err_x;
      logic [31:0] rd_x;
      logic        chk_rd;
      int          lat;
      int          wr_cyc;
      logic [31:0] wr_adr;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   memctrl #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
      .adr(adr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .memwrite(memwrite), .madr(madr), .mwritedata(mwritedata), .memdata(memdata)
   );

   assign memdata = mem[madr[9:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (memwrite) wr_cnt <= wr_cnt + 1;
      if (init_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h40] <= 32'h80818283;
      end else if (memwrite) begin
         mem[madr[9:2]] <= mwritedata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic ex, input logic [31:0] rd, input logic cr,
                               input int lat, input int wc, input logic [31:0] wa);
      exp_t e;
      e.err_x = ex; e.rd_x = rd; e.chk_rd = cr; e.lat = lat; e.wr_cyc = wc; e.wr_adr = wa;
      return e;
   endfunction

   // Cycle 0 is the IDLE cycle where req is first seen; k counts cycles from it.
   task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d, input exp_t e,
                         output int rdy_cyc);
      exp_t        got;
      int          k, wc, nwr;
      logic [31:0] wa;
      logic        seen;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sext = sx; adr = a; wdata = d;
      sb.push_back(e);
      k = 0; wc = -1; nwr = 0; wa = 32'h0; seen = 1'b0; rdy_cyc = -1;
      while (!seen && k <= 8) begin
         #1;
         if (memwrite) begin nwr++; wc = k; wa = madr; end
         if (ready) seen = 1'b1;
         else begin @(negedge clk); k++; end
      end
      got = sb.pop_front();
      chk({tag, "/ready"}, 32'(seen), 32'd1);
      if (seen) begin
         rdy_cyc = cyc;
         chk({tag, "/latency"}, 32'(k), 32'(got.lat));
         chk({tag, "/err"}, 32'(err), 32'(got.err_x));
         if (got.chk_rd) chk({tag, "/rdata"}, rdata, got.rd_x);
         chk({tag, "/writes"}, 32'(nwr), (got.wr_cyc >= 0) ? 32'd1 : 32'd0);
         if (got.wr_cyc >= 0) begin
            chk({tag, "/wr_cycle"}, 32'(wc), 32'(got.wr_cyc));
            chk({tag, "/wr_madr"}, wa, got.wr_adr);
         end
      end
      req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2, w0;
      reset = 1'b1; init_mem = 1'b1; req = 1'b0; we = 1'b0; size = SZ_BYTE;
      sext = 1'b0; adr = 32'h0; wdata = 32'h0;
      repeat (3) @(negedge clk);
      init_mem = 1'b0;
      #1;
      chk("rst/ready", 32'(ready), 32'd0);
      chk("rst/err", 32'(err), 32'd0);
      chk("rst/rdata", rdata, 32'h0);
      chk("rst/memwrite", 32'(memwrite), 32'd0);
      reset = 1'b0;

      do_req("lb101",  1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, mk(0, 32'hFFFFFF81, 1, 1, -1, 0), c1);
      do_req("lhu102", 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, mk(0, 32'h00008283, 1, 1, -1, 0), c1);
      do_req("lh100",  1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, mk(0, 32'hFFFF8081, 1, 1, -1, 0), c1);
      do_req("lbu100", 1'b0, SZ_BYTE, 1'b0, 32'h100, 32'h0, mk(0, 32'h00000080, 1, 1, -1, 0), c1);
      do_req("lb103",  1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, mk(0, 32'hFFFFFF83, 1, 1, -1, 0), c1);
      do_req("lw100",  1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, mk(0, 32'h80818283, 1, 1, -1, 0), c1);

      do_req("sb103", 1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h123456AA, mk(0, 0, 0, 2, 1, 32'h100), c1);
      chk("mem_after_sb", mem[8'h40], 32'h808182AA);
      do_req("sh100", 1'b1, SZ_HALF, 1'b0, 32'h100, 32'h0000BEEF, mk(0, 0, 0, 2, 1, 32'h100), c1);
      chk("mem_after_sh", mem[8'h40], 32'hBEEF82AA);

      do_req("lw102_err",  1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, mk(1, 32'h0, 1, 1, -1, 0), c1);
      do_req("sh101_err",  1'b1, SZ_HALF, 1'b0, 32'h101, 32'h5555, mk(1, 32'h0, 1, 1, -1, 0), c1);
      do_req("rsvd_err",   1'b1, SZ_RSVD, 1'b0, 32'h100, 32'h77777777, mk(1, 32'h0, 1, 1, -1, 0), c1);
      chk("mem_after_err", mem[8'h40], 32'hBEEF82AA);
      @(negedge clk); #1;
      chk("err_hold", 32'(err), 32'd1);
      chk("ready_idle", 32'(ready), 32'd0);

      // Byte store aborted by reset during its write cycle.
      w0 = wr_cnt;
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = SZ_BYTE; sext = 1'b0; adr = 32'h101; wdata = 32'h55;
      @(negedge clk);
      reset = 1'b1; req = 1'b0;
      #1;
      chk("rst_rmw/memwrite", 32'(memwrite), 32'd0);
      chk("rst_rmw/ready", 32'(ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("rst_rmw/no_ready", 32'(ready), 32'd0);
         @(negedge clk);
      end
      chk("rst_rmw/no_write", 32'(wr_cnt - w0), 32'd0);
      chk("rst_rmw/mem", mem[8'h40], 32'hBEEF82AA);
      do_req("lw_after_rst", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, mk(0, 32'hBEEF82AA, 1, 1, -1, 0), c1);

      do_req("sw200", 1'b1, SZ_WORD, 1'b0, 32'h200, 32'hDEADBEEF, mk(0, 0, 0, 1, 0, 32'h200), c1);
      do_req("lw200", 1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0, mk(0, 32'hDEADBEEF, 1, 1, -1, 0), c2);
      chk("b2b_spacing", 32'(c2 - c1), 32'd2);
      chk("mem200", mem[8'h80], 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
